// File: rtl/mem_bus_arbiter.sv
// Arbitrates a single memory port between a CPU data port and a DMA master.
// DMA wins only while no CPU access is in flight; the bus is handed back through a one-cycle release.
module mem_bus_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int BLOCK_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_readM,
  input  logic                  cpu_writeM,
  input  logic [WORD_SIZE-1:0]  cpu_address,
  input  logic [BLOCK_SIZE-1:0] cpu_wdata,
  output logic [BLOCK_SIZE-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  BR,
  output logic                  BG,
  input  logic                  dma_WRITE,
  input  logic [WORD_SIZE-1:0]  dma_addr,
  input  logic [BLOCK_SIZE-1:0] dma_data,
  output logic                  mem_readM,
  output logic                  mem_writeM,
  output logic [WORD_SIZE-1:0]  mem_address,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [15:0]           dma_cycles,
  output logic [15:0]           stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CPU_ACC = 2'd1,
    S_DMA_OWN = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_bg;
  logic [BLOCK_SIZE-1:0] r_rdata;
  logic [15:0]           r_dma_cycles;
  logic [15:0]           r_stall_cycles;

  logic w_cpu_req;
  logic w_cpu_own;
  logic w_stall;
  logic w_rd;
  logic w_wr;

  assign w_cpu_req = cpu_readM | cpu_writeM;
  // The CPU owns the port in CPU_ACC, or in IDLE when DMA is not asking; nobody owns it during reset.
  assign w_cpu_own = ~reset & ((r_state == S_CPU_ACC) | ((r_state == S_IDLE) & ~BR));
  assign w_stall   = w_cpu_req & (~w_cpu_own | ~mem_ready);

  // Owner-based steering of the memory port.
  always_comb begin
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    mem_address = {WORD_SIZE{1'b0}};
    mem_wdata   = {BLOCK_SIZE{1'b0}};
    if (w_cpu_own) begin
      w_rd        = cpu_readM;
      w_wr        = cpu_writeM;
      mem_address = cpu_address;
      mem_wdata   = cpu_wdata;
    end else if (r_state == S_DMA_OWN) begin
      w_rd        = 1'b0;
      w_wr        = dma_WRITE;
      mem_address = dma_addr;
      mem_wdata   = dma_data;
    end else begin
      w_rd        = 1'b0;
      w_wr        = 1'b0;
    end
  end

  assign mem_readM    = w_rd & ~reset;
  assign mem_writeM   = w_wr & ~reset;
  assign cpu_rdata    = w_cpu_own ? mem_rdata : r_rdata;
  assign cpu_stall    = w_stall;
  assign BG           = r_bg;
  assign dma_cycles   = r_dma_cycles;
  assign stall_cycles = r_stall_cycles;

  // Ownership FSM with registered grant, read-data hold and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_bg           <= 1'b0;
      r_rdata        <= {BLOCK_SIZE{1'b0}};
      r_dma_cycles   <= 16'h0000;
      r_stall_cycles <= 16'h0000;
    end else begin
      if (w_cpu_own) r_rdata <= mem_rdata;
      if ((r_state == S_DMA_OWN) && (r_dma_cycles != 16'hFFFF)) r_dma_cycles <= r_dma_cycles + 16'd1;
      if (w_stall && (r_stall_cycles != 16'hFFFF)) r_stall_cycles <= r_stall_cycles + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (BR) begin
            r_state <= S_DMA_OWN;
            r_bg    <= 1'b1;
          end else if (w_cpu_req && !mem_ready) begin
            r_state <= S_CPU_ACC;
            r_bg    <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_bg    <= 1'b0;
          end
        end
        S_CPU_ACC: begin
          if (mem_ready) begin
            r_state <= BR ? S_DMA_OWN : S_IDLE;
            r_bg    <= BR;
          end else begin
            r_state <= S_CPU_ACC;
            r_bg    <= 1'b0;
          end
        end
        S_DMA_OWN: begin
          if (!BR) begin
            r_state <= S_RELEASE;
            r_bg    <= 1'b0;
          end else begin
            r_state <= S_DMA_OWN;
            r_bg    <= 1'b1;
          end
        end
        S_RELEASE: begin
          r_state <= S_IDLE;
          r_bg    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_bg    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter, checked against an ownership-rule model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset, cpu_readM, cpu_writeM, BR, dma_WRITE, mem_ready;
  logic [15:0] cpu_address, dma_addr;
  logic [63:0] cpu_wdata, dma_data, mem_rdata;
  logic [63:0] cpu_rdata, mem_wdata;
  logic [15:0] mem_address, dma_cycles, stall_cycles;
  logic        cpu_stall, BG, mem_readM, mem_writeM;

  int checks = 0;
  int failures = 0;
  bit do_chk = 1'b1;

  // Model: who holds the bus, expressed as ownership facts rather than states.
  bit          m_dma, m_rel, m_inflight;
  logic [63:0] m_hold;
  int          m_dmac, m_stallc;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WORD_SIZE(16), .BLOCK_SIZE(64)) dut (
    .clk(clk), .reset(reset), .cpu_readM(cpu_readM), .cpu_writeM(cpu_writeM),
    .cpu_address(cpu_address), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .BR(BR), .BG(BG), .dma_WRITE(dma_WRITE), .dma_addr(dma_addr),
    .dma_data(dma_data), .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .dma_cycles(dma_cycles), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cpu_owns();
    return !reset && (m_inflight || (!m_dma && !m_rel && !m_inflight && !BR));
  endfunction

  function automatic bit exp_stall();
    return (cpu_readM || cpu_writeM) && (!cpu_owns() || !mem_ready);
  endfunction

  task automatic compare_outputs();
    logic [15:0] ea;
    logic [63:0] ew;
    logic        er, eww;
    if (cpu_owns()) begin
      ea = cpu_address; ew = cpu_wdata; er = cpu_readM; eww = cpu_writeM;
    end else if (m_dma) begin
      ea = dma_addr; ew = dma_data; er = 1'b0; eww = dma_WRITE;
    end else begin
      ea = 16'h0000; ew = 64'h0; er = 1'b0; eww = 1'b0;
    end
    if (reset) begin
      er = 1'b0; eww = 1'b0;
    end
    chk("mem_address", {48'h0, mem_address}, {48'h0, ea});
    chk("mem_wdata", mem_wdata, ew);
    chk("mem_readM", {63'h0, mem_readM}, {63'h0, er});
    chk("mem_writeM", {63'h0, mem_writeM}, {63'h0, eww});
    chk("cpu_stall", {63'h0, cpu_stall}, {63'h0, exp_stall()});
    chk("cpu_rdata", cpu_rdata, cpu_owns() ? mem_rdata : m_hold);
    chk("BG", {63'h0, BG}, {63'h0, m_dma});
    chk("dma_cycles", {48'h0, dma_cycles}, 64'(m_dmac));
    chk("stall_cycles", {48'h0, stall_cycles}, 64'(m_stallc));
  endtask

  task automatic model_edge();
    bit own, st, req;
    own = cpu_owns();
    st  = exp_stall();
    req = cpu_readM || cpu_writeM;
    if (reset) begin
      m_dma = 0; m_rel = 0; m_inflight = 0; m_hold = 64'h0; m_dmac = 0; m_stallc = 0;
    end else begin
      if (m_dma && m_dmac < 65535) m_dmac++;
      if (st && m_stallc < 65535) m_stallc++;
      if (own) m_hold = mem_rdata;
      if (m_rel) begin
        m_rel = 0;
      end else if (m_dma) begin
        if (!BR) begin m_dma = 0; m_rel = 1; end
      end else if (m_inflight) begin
        if (mem_ready) begin m_inflight = 0; m_dma = BR; end
      end else if (BR) begin
        m_dma = 1;
      end else if (req && !mem_ready) begin
        m_inflight = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (do_chk) compare_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    reset = 1'b0; cpu_readM = 1'b0; cpu_writeM = 1'b0; BR = 1'b0; dma_WRITE = 1'b0;
    mem_ready = 1'b0; cpu_address = 16'h0; dma_addr = 16'h0;
    cpu_wdata = 64'h0; dma_data = 64'h0; mem_rdata = 64'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    m_dma = 0; m_rel = 0; m_inflight = 0; m_hold = 64'h0; m_dmac = 0; m_stallc = 0;
    quiet();
    do_chk = 1'b0;
    do_reset();
    do_chk = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_BG", {63'h0, BG}, 64'h0);
    chk("rst_dma_cycles", {48'h0, dma_cycles}, 64'h0);
    chk("rst_stall_cycles", {48'h0, stall_cycles}, 64'h0);
    chk("rst_cpu_rdata_hold", cpu_rdata, 64'h0);
    @(posedge clk); #1;

    // Three-cycle CPU read at 0x0040
    cpu_readM = 1'b1; cpu_address = 16'h0040; mem_rdata = 64'hDEAD_BEEF_0000_0040;
    tick(); tick();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("read3_rdata", cpu_rdata, 64'hDEAD_BEEF_0000_0040);
    chk("read3_addr", {48'h0, mem_address}, 64'h0040);
    @(posedge clk); model_edge(); #1;
    quiet();
    @(negedge clk);
    chk("read3_stall_cycles", {48'h0, stall_cycles}, 64'd2);
    @(posedge clk); model_edge(); #1;

    // Single-cycle write in IDLE: no stall, stays IDLE
    cpu_writeM = 1'b1; cpu_address = 16'h0123; cpu_wdata = 64'h1111; mem_ready = 1'b1;
    tick();
    quiet();
    tick();
    chk("single_stall_cycles", {48'h0, stall_cycles}, 64'd2);

    // BR during an in-flight CPU access waits for mem_ready
    cpu_readM = 1'b1; cpu_address = 16'h0200; mem_rdata = 64'h55;
    tick();
    BR = 1'b1; dma_addr = 16'h0300;
    tick();
    mem_ready = 1'b1;
    tick();
    cpu_readM = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk("preempt_BG", {63'h0, BG}, 64'h1);
    chk("preempt_dma_addr", {48'h0, mem_address}, 64'h0300);
    @(posedge clk); model_edge(); #1;
    dma_WRITE = 1'b1; dma_addr = 16'h01F4; dma_data = 64'hABCD;
    @(negedge clk);
    chk("dmaw_writeM", {63'h0, mem_writeM}, 64'h1);
    chk("dmaw_readM", {63'h0, mem_readM}, 64'h0);
    chk("dmaw_addr", {48'h0, mem_address}, 64'h01F4);
    @(posedge clk); model_edge(); #1;

    // Reset while DMA owns the bus
    reset = 1'b1;
    tick();
    quiet();
    @(negedge clk);
    chk("dmarst_BG", {63'h0, BG}, 64'h0);
    chk("dmarst_dma_cycles", {48'h0, dma_cycles}, 64'h0);
    chk("dmarst_stall_cycles", {48'h0, stall_cycles}, 64'h0);
    @(posedge clk); model_edge(); #1;

    // BR and CPU write together; 12 DMA cycles, release, then the write
    BR = 1'b1; cpu_writeM = 1'b1; cpu_address = 16'h0777; cpu_wdata = 64'h77;
    repeat (12) tick();
    BR = 1'b0;
    tick();
    @(negedge clk);
    chk("rel_stall", {63'h0, cpu_stall}, 64'h1);
    chk("rel_writeM", {63'h0, mem_writeM}, 64'h0);
    @(posedge clk); model_edge(); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("after_rel_writeM", {63'h0, mem_writeM}, 64'h1);
    chk("after_rel_addr", {48'h0, mem_address}, 64'h0777);
    @(posedge clk); model_edge(); #1;
    quiet();
    @(negedge clk);
    chk("dma12_dma_cycles", {48'h0, dma_cycles}, 64'd12);
    chk("dma12_stall_cycles", {48'h0, stall_cycles}, 64'd14);
    @(posedge clk); model_edge(); #1;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      cpu_readM  = ($urandom_range(0, 2) == 0);
      cpu_writeM = !cpu_readM && ($urandom_range(0, 3) == 0);
      cpu_address = 16'($urandom);
      cpu_wdata  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) BR = ~BR;
      dma_WRITE  = 1'($urandom);
      dma_addr   = 16'($urandom);
      dma_data   = {$urandom, $urandom};
      mem_rdata  = {$urandom, $urandom};
      mem_ready  = ($urandom_range(0, 2) == 0);
      tick();
    end

    // Long DMA ownership saturates the counter
    quiet();
    do_reset();
    BR = 1'b1;
    do_chk = 1'b0;
    repeat (70000) tick();
    do_chk = 1'b1;
    @(negedge clk);
    chk("sat_dma_cycles", {48'h0, dma_cycles}, 64'hFFFF);
    chk("sat_model", {48'h0, dma_cycles}, 64'(m_dmac));
    @(posedge clk); model_edge(); #1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
